fixed_mul: RTL and testbench

FIXED_MUL -- requirements
Module: fixed_mul

---
 rtl/fixed_pkg.sv | 23 ++
 rtl/fixed_mul.sv | 188 ++++++++++++++++++
 tb/tb_fixed_mul.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (multiplier, divider).
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: default operand format, operation state enumeration, SMALLEST operand.
package fixed_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FBITS = 16;

  // Operation sequence shared by the iterative arithmetic units.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CALC  = 3'd2,
    S_ROUND = 3'd3,
    S_SIGN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Most negative value at the default width; its magnitude is not representable.
  localparam logic [DEF_WIDTH-1:0] SMALLEST = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fixed_mul.sv
// Signed Q(WIDTH-FBITS).FBITS multiplier: iterative shift-add, round-half-to-even.
// Latency: done after edge WIDTH+2 from accepted start; after edge 1 for a SMALLEST operand.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
// Ports: clk/rst (async active-high), start, write_a/a_in load operand A, b multiplier,
//        busy, done (1-cycle pulse), valid/ovf status, val signed rounded product.
module fixed_mul
  import fixed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS   // assumed 0 <= FBITS <= WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             write_a,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  output logic [WIDTH-1:0] val
);

  localparam int MW = WIDTH - 1;          // magnitude width
  localparam int AW = 2 * MW;             // accumulator width
  localparam int QW = AW - FBITS + 1;     // rounded quotient incl. carry bit
  localparam int CW = $clog2(WIDTH);

  // Width-generic form of the package SMALLEST constant.
  localparam logic [WIDTH-1:0] SMALLEST_W = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [MW-1:0] mag(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] neg_x;
    neg_x = ~x + 1'b1;
    return x[WIDTH-1] ? neg_x[MW-1:0] : x[MW-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_reg;
  logic [AW-1:0]    mcand;
  logic [MW-1:0]    mplier;
  logic             neg;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [QW-1:0]    q_reg;

  logic is_smallest, calc_last;
  logic ld_ops, clr_acc, step, ld_q, fin_sign, fin_done;

  assign is_smallest = (a_reg == SMALLEST_W) || (b == SMALLEST_W);
  assign calc_last   = (cnt == CW'(MW - 1));

  // Operand A is loadable at any time; the running operation works from its own copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          a_reg <= '0;
    else if (write_a) a_reg <= a_in;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = is_smallest ? S_DONE : S_INIT;
      S_INIT:  state_d = S_CALC;
      S_CALC:  if (calc_last) state_d = S_ROUND;
      S_ROUND: state_d = S_SIGN;
      S_SIGN:  state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: output decode ----------------
  always_comb begin
    ld_ops   = 1'b0;
    clr_acc  = 1'b0;
    step     = 1'b0;
    ld_q     = 1'b0;
    fin_sign = 1'b0;
    fin_done = 1'b0;
    case (state_q)
      S_IDLE:  ld_ops   = start;
      S_INIT:  clr_acc  = 1'b1;
      S_CALC:  step     = 1'b1;
      S_ROUND: ld_q     = 1'b1;
      S_SIGN:  fin_sign = 1'b1;
      S_DONE:  fin_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- rounding (combinational) ----------------
  logic              r_bit, s_bit;
  logic [AW-FBITS-1:0] q_trunc;
  logic [QW-1:0]     q_rnd;

  assign q_trunc = acc[AW-1:FBITS];

  generate
    if (FBITS == 0) begin : g_no_round
      assign r_bit = 1'b0;
      assign s_bit = 1'b0;
    end else if (FBITS == 1) begin : g_round_only
      assign r_bit = acc[0];
      assign s_bit = 1'b0;
    end else begin : g_round_sticky
      assign r_bit = acc[FBITS-1];
      assign s_bit = |acc[FBITS-2:0];
    end
  endgenerate

  // Round half to even: a pure half only rounds up when Q is odd.
  assign q_rnd = {1'b0, q_trunc} + QW'(r_bit & (s_bit | q_trunc[0]));

  // Low WIDTH bits of the rounded magnitude and their negation.
  logic [WIDTH-1:0] q_low, q_neg;
  logic             q_big;
  assign q_low = q_reg[WIDTH-1:0];
  assign q_neg = ~q_low + 1'b1;
  assign q_big = |q_reg[QW-1:MW];   // magnitude >= 2^(WIDTH-1)

  // ---------------- datapath / registered outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      q_reg  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
      val    <= '0;
    end else begin
      done <= 1'b0;
      if (ld_ops) begin
        valid <= 1'b0;
        ovf   <= 1'b0;
        if (is_smallest) begin
          ovf <= 1'b1;
        end else begin
          mcand  <= {{MW{1'b0}}, mag(a_reg)};
          mplier <= mag(b);
          neg    <= a_reg[WIDTH-1] ^ b[WIDTH-1];
          busy   <= 1'b1;
        end
      end
      if (clr_acc) begin
        acc <= '0;
        cnt <= '0;
      end
      // Multiplier shifts right, multiplicand left: bit cnt of |b| weights |A| << cnt.
      if (step) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (ld_q) q_reg <= q_rnd;
      if (fin_sign) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (q_big) begin
          ovf   <= 1'b1;
          valid <= 1'b0;
        end else begin
          // -0 is 0, so a zero magnitude never produces a negative result.
          val   <= neg ? q_neg : q_low;
          valid <= 1'b1;
        end
      end
      if (fin_done) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mul.sv
// Self-checking bench for fixed_mul: directed and random operations, scoreboard + monitor.
// Latency checked: done cycle compared against the expected edge of each operation.
// Backpressure: start held continuously in the throughput section.
module tb_fixed_mul;

  localparam int W = 32;
  localparam int F = 16;
  localparam logic [W-1:0] SMALL = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         write_a = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, valid, ovf;
  logic [W-1:0] val;

  fixed_mul #(.WIDTH(W), .FBITS(F)) dut (
    .clk(clk), .rst(rst), .start(start), .write_a(write_a), .a_in(a_in), .b(b),
    .busy(busy), .done(done), .valid(valid), .ovf(ovf), .val(val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int           due;
    logic [W-1:0] val;
    logic         valid;
    logic         ovf;
  } exp_t;

  exp_t         sbq[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] a_model = '0;
  logic [W-1:0] val_model = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer product of magnitudes, then round-half-to-even on the
  // discarded fraction, then range check and sign.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] bb, input int acc_edge);
    exp_t e;
    longint sa, sb;
    longint unsigned ma, mb, p, q, rem, half, res;
    bit ng;
    if (a == SMALL || bb == SMALL) begin
      e.due = acc_edge + 1; e.val = val_model; e.valid = 1'b0; e.ovf = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(bb));
      ma = (sa < 0) ? longint'(-sa) : longint'(sa);
      mb = (sb < 0) ? longint'(-sb) : longint'(sb);
      ng = (sa < 0) != (sb < 0);
      p = ma * mb;
      q = p >> F;
      rem = p & ((64'd1 << F) - 1);
      half = 64'd1 << (F - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      e.due = acc_edge + W + 2;
      if (q >= (64'd1 << (W - 1))) begin
        e.val = val_model; e.valid = 1'b0; e.ovf = 1'b1;
      end else begin
        res = ng ? -q : q;
        e.val = res[W-1:0]; e.valid = 1'b1; e.ovf = 1'b0;
        val_model = e.val;
      end
    end
    sbq.push_back(e);
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        exp_t e;
        check("done_gap", prev_done, 0);
        check("busy_at_done", busy, 0);
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          check("done_cycle", cyc, e.due);
          check("val", val, e.val);
          check("valid", valid, e.valid);
          check("ovf", ovf, e.ovf);
        end
      end
      prev_done = done;
    end
  end

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] m;
    m = ($urandom & 32'h7FFF_FFFF) >> $urandom_range(8, 31);
    return ($urandom_range(0, 1) == 1) ? (~m + 1'b1) : m;
  endfunction

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: got no done expected done within 100 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] bb);
    @(negedge clk);
    write_a = 1'b1; a_in = a; start = 1'b0;
    @(negedge clk);
    write_a = 1'b0; a_model = a; start = 1'b1; b = bb;
    push_exp(a_model, bb, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, (a == SMALL || bb == SMALL) ? 0 : 1);
    wait_done();
  endtask

  // start held high; A rewritten mid-operation must not affect the running product.
  task automatic cont_run(input int nops);
    int  k, cnt;
    bit  got;
    @(negedge clk);
    write_a = 1'b1; a_in = rnd_op(); start = 1'b0;
    @(negedge clk);
    write_a = 1'b0; a_model = a_in; start = 1'b1; b = rnd_op();
    push_exp(a_model, b, cyc + 1);
    for (int i = 0; i < nops; i++) begin
      k = $urandom_range(3, 28);
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 100) begin
        @(negedge clk);
        cnt++;
        if (write_a) begin
          a_model = a_in;
          write_a = 1'b0;
        end
        if (cnt == k) begin
          write_a = 1'b1;
          a_in = rnd_op();
        end
        b = rnd_op();
        if (done) begin
          got = 1'b1;
          if (i < nops - 1) push_exp(a_model, b, cyc + 1);
          else start = 1'b0;
        end
      end
      if (!got) begin
        n_cmp++; n_bad++;
        $display("FAIL cont_timeout: got no done expected done (cycle %0d)", cyc);
        start = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_val", val, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h0001_8000, 32'h0002_0000);
    run_op(32'hFFFE_8000, 32'h0002_0000);
    run_op(32'h0000_0000, 32'hFFFF_0000);
    run_op(32'h0000_0001, 32'h0000_8000);
    run_op(32'h0000_0003, 32'h0000_8000);
    run_op(32'h0000_0003, 32'h0000_C000);
    run_op(32'hFFFF_8000, 32'hFFFF_8000);
    run_op(32'h0100_0000, 32'h0100_0000);
    run_op(32'h8000_0000, 32'h0001_0000);
    run_op(32'h0001_0000, 32'h8000_0000);
    run_op(32'h7FFF_FFFF, 32'h0000_FFFF);

    for (int i = 0; i < 30; i++) run_op(rnd_op(), rnd_op());

    // Abort mid-CALC: outputs clear at once and no done follows.
    @(negedge clk);
    write_a = 1'b1; a_in = 32'h0001_8000;
    @(negedge clk);
    write_a = 1'b0; start = 1'b1; b = 32'h0002_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", valid, 0);
    check("abort_ovf", ovf, 0);
    check("abort_val", val, 0);
    a_model = '0;
    val_model = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_queue_empty", sbq.size(), 0);
    run_op(32'h0001_8000, 32'h0002_0000);

    cont_run(5);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
